// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/halt controller: resolves hazards into PC/IF/ID/ID/EX controls,
// runs the RUN/HALTED/STEP machine and keeps saturating statistics counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loaduse_i,
    input  logic             branch_taken_i,
    input  logic             jump_id_i,
    input  logic             halt_req_i,
    input  logic             go_i,
    input  logic             step_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_clr_o,
    output logic             idex_clr_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             go_q, step_q;
    logic             go_rise, step_rise;
    logic             stall_inc, flush_inc, cycle_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    assign go_rise   = go_i & ~go_q;
    assign step_rise = step_i & ~step_q;

    always_comb begin
        state_d    = state_q;
        pc_en_o    = 1'b1;
        ifid_en_o  = 1'b1;
        ifid_clr_o = 1'b0;
        idex_clr_o = 1'b0;
        halted_o   = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        cycle_inc  = 1'b0;
        case (state_q)
            ST_HALTED: begin
                // Front end frozen; ID/EX keeps injecting bubbles so the back end drains.
                pc_en_o    = 1'b0;
                ifid_en_o  = 1'b0;
                idex_clr_o = 1'b1;
                halted_o   = 1'b1;
                if (go_rise) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                cycle_inc = 1'b1;
                if (state_q == ST_STEP) begin
                    state_d = ST_HALTED;
                end
                if (halt_req_i) begin
                    pc_en_o    = 1'b0;
                    ifid_en_o  = 1'b0;
                    idex_clr_o = 1'b1;
                    state_d    = ST_HALTED;
                end else if (branch_taken_i) begin
                    // Instruction in ID is wrong-path, so its loaduse/jump are moot.
                    ifid_clr_o = 1'b1;
                    idex_clr_o = 1'b1;
                    flush_inc  = 1'b1;
                end else if (loaduse_i) begin
                    pc_en_o    = 1'b0;
                    ifid_en_o  = 1'b0;
                    idex_clr_o = 1'b1;
                    stall_inc  = 1'b1;
                end else if (jump_id_i) begin
                    ifid_clr_o = 1'b1;
                    flush_inc  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (stall_inc && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_inc && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
        if (cycle_inc && cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            go_q        <= 1'b0;
            step_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_i;
            step_q      <= step_i;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a behavioural model pushes expected
// outputs per cycle into a queue that is popped and compared against the DUT.
module tb_pipe_hazard_ctrl;

    localparam int EXP_W = 55;  // {ctrl[4:0], state[1:0], stall, flush, cycle}
    localparam logic [1:0] M_RUN = 2'd0, M_HALTED = 2'd1, M_STEP = 2'd2;

    logic clk, rst_n;
    logic loaduse, branch_taken, jump_id, halt_req, go, step;
    logic pc_en, ifid_en, ifid_clr, idex_clr, halted;
    logic [15:0] stall_cnt, flush_cnt, cycle_cnt;
    logic [1:0] state;
    logic pc_en4, ifid_en4, ifid_clr4, idex_clr4, halted4;
    logic [3:0] stall_cnt4, flush_cnt4, cycle_cnt4;
    logic [1:0] state4;

    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [1:0] m_state;
    logic m_go_q, m_step_q;
    int m_stall, m_flush, m_cycle;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .loaduse_i(loaduse), .branch_taken_i(branch_taken),
        .jump_id_i(jump_id), .halt_req_i(halt_req), .go_i(go), .step_i(step),
        .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_clr_o(ifid_clr), .idex_clr_o(idex_clr),
        .halted_o(halted), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
        .cycle_cnt_o(cycle_cnt), .state_o(state)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .loaduse_i(loaduse), .branch_taken_i(branch_taken),
        .jump_id_i(jump_id), .halt_req_i(halt_req), .go_i(go), .step_i(step),
        .pc_en_o(pc_en4), .ifid_en_o(ifid_en4), .ifid_clr_o(ifid_clr4), .idex_clr_o(idex_clr4),
        .halted_o(halted4), .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4),
        .cycle_cnt_o(cycle_cnt4), .state_o(state4)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_state  = M_RUN;
        m_go_q   = 1'b0;
        m_step_q = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
        m_cycle  = 0;
    endtask

    task automatic do_reset();
        loaduse = 0; branch_taken = 0; jump_id = 0; halt_req = 0; go = 0; step = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock cycle: drive at negedge, push model expectation, pop and compare, advance model.
    task automatic cyc(input logic lu, input logic br, input logic jp,
                       input logic hr, input logic g, input logic s);
        logic [4:0] e_ctrl;  // {pc_en, ifid_en, ifid_clr, idex_clr, halted}
        logic [1:0] n_state;
        logic g_rise, s_rise;
        logic [EXP_W-1:0] exp_v;
        @(negedge clk);
        loaduse = lu; branch_taken = br; jump_id = jp; halt_req = hr; go = g; step = s;
        g_rise = g && !m_go_q;
        s_rise = s && !m_step_q;
        n_state = m_state;
        exp_v = {5'b0, m_state, 16'(sat(m_stall, 65535)), 16'(sat(m_flush, 65535)),
                 16'(sat(m_cycle, 65535))};
        if (m_state == M_HALTED) begin
            e_ctrl = 5'b00011;
            if (g_rise) n_state = M_RUN;
            else if (s_rise) n_state = M_STEP;
        end else begin
            e_ctrl = 5'b11000;
            m_cycle++;
            if (m_state == M_STEP) n_state = M_HALTED;
            if (hr) begin
                e_ctrl = 5'b00010;
                n_state = M_HALTED;
            end else if (br) begin
                e_ctrl = 5'b11110;
                m_flush++;
            end else if (lu) begin
                e_ctrl = 5'b00010;
                m_stall++;
            end else if (jp) begin
                e_ctrl = 5'b11100;
                m_flush++;
            end
        end
        exp_v[54:50] = e_ctrl;
        exp_q.push_back(exp_v);
        #1;
        exp_v = exp_q.pop_front();
        check_eq("ctrl", {27'd0, pc_en, ifid_en, ifid_clr, idex_clr, halted}, 32'(exp_v[54:50]));
        check_eq("state", {30'd0, state}, 32'(exp_v[49:48]));
        check_eq("stall_cnt", {16'd0, stall_cnt}, 32'(exp_v[47:32]));
        check_eq("flush_cnt", {16'd0, flush_cnt}, 32'(exp_v[31:16]));
        check_eq("cycle_cnt", {16'd0, cycle_cnt}, 32'(exp_v[15:0]));
        check_eq("ctrl4", {27'd0, pc_en4, ifid_en4, ifid_clr4, idex_clr4, halted4}, 32'(exp_v[54:50]));
        m_state  = n_state;
        m_go_q   = g;
        m_step_q = s;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        #1;
        // Reset values with all inputs low
        check_eq("rst_ctrl", {27'd0, pc_en, ifid_en, ifid_clr, idex_clr, halted}, 32'b11000);
        check_eq("rst_cycle", {16'd0, cycle_cnt}, 32'd0);
        check_eq("rst_stall", {16'd0, stall_cnt}, 32'd0);
        check_eq("rst_state", {30'd0, state}, 32'd0);

        // Idle 10 cycles
        repeat (10) cyc(0, 0, 0, 0, 0, 0);
        settle();
        check_eq("idle_cycle", {16'd0, cycle_cnt}, 32'd10);
        check_eq("idle_stall", {16'd0, stall_cnt}, 32'd0);
        check_eq("idle_flush", {16'd0, flush_cnt}, 32'd0);

        // loaduse, then loaduse + jump
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        settle();
        check_eq("lu_stall", {16'd0, stall_cnt}, 32'd2);
        check_eq("lu_flush", {16'd0, flush_cnt}, 32'd0);

        // branch overrides loaduse and jump
        do_reset();
        cyc(1, 1, 1, 0, 0, 0);
        settle();
        check_eq("br_flush", {16'd0, flush_cnt}, 32'd1);
        check_eq("br_stall", {16'd0, stall_cnt}, 32'd0);

        // halt_req on cycle 5, then idle with stray branches
        do_reset();
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, (i % 3) == 0, i[0], 0, 0, 0);
        settle();
        check_eq("halt_cycle", {16'd0, cycle_cnt}, 32'd5);
        check_eq("halt_flag", {31'd0, halted}, 32'd1);
        check_eq("halt_flush", {16'd0, flush_cnt}, 32'd0);

        // step held 4 cycles: one STEP cycle only
        repeat (4) cyc(0, 0, 0, 0, 0, 1);
        settle();
        check_eq("step_cycle", {16'd0, cycle_cnt}, 32'd6);
        check_eq("step_state", {30'd0, state}, 32'(M_HALTED));

        // go and step together: go wins, stays RUN while held
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 0, 1, 1);
        settle();
        check_eq("go_state", {30'd0, state}, 32'(M_RUN));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        // Saturation of the 4-bit instance
        do_reset();
        repeat (20) cyc(1, 0, 0, 0, 0, 0);
        settle();
        check_eq("sat_stall4", {28'd0, stall_cnt4}, 32'd15);
        check_eq("sat_cycle4", {28'd0, cycle_cnt4}, 32'd15);
        check_eq("sat_stall16", {16'd0, stall_cnt}, 32'd20);

        // Asynchronous reset while halted
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_state", {30'd0, state}, 32'(M_RUN));
        check_eq("arst_halted", {31'd0, halted}, 32'd0);
        check_eq("arst_stall", {16'd0, stall_cnt}, 32'd0);
        check_eq("arst_cycle", {16'd0, cycle_cnt}, 32'd0);
        check_eq("arst_stall4", {28'd0, stall_cnt4}, 32'd0);
        check_eq("arst_pc_en", {31'd0, pc_en}, 32'd1);
        do_reset();
        repeat (3) cyc(0, 0, 0, 0, 0, 0);

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
